// File: rtl/inv_shift_row_pkg.sv
// Shared AES definitions: state width, state/byte types and the ShiftRows byte maps.
// Imported by both the forward and the inverse ShiftRows blocks.
package inv_shift_row_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int NUM_BYTES  = DATA_WIDTH / 8;

  typedef logic [7:0]            byte_t;
  typedef logic [DATA_WIDTH-1:0] state_t;

  // Source in-byte for each out-byte; byte b = 4*col + row, byte 0 at the MSBs.
  localparam logic [3:0] INV_SR_MAP [NUM_BYTES] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  localparam logic [3:0] FWD_SR_MAP [NUM_BYTES] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  function automatic byte_t get_byte(input state_t s, input int b);
    return s[DATA_WIDTH-1-8*b -: 8];
  endfunction

endpackage

// File: rtl/inv_shift_row_perm.sv
// Pure-wiring InvShiftRows permutation: row r of the state rotated right by r bytes.
module inv_shift_row_perm
  import inv_shift_row_pkg::*;
(
  input  state_t data_in,
  output state_t data_out
);

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    assign data_out[DATA_WIDTH-1-8*gi -: 8] = get_byte(data_in, int'(INV_SR_MAP[gi]));
  end

endmodule

// File: rtl/inv_shift_row.sv
// InvShiftRows stage with a small output FIFO and valid/ready handshakes on both sides.
// The permutation is applied on the way in, so the buffer holds finished states.
module inv_shift_row #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     invShiftRow_valid_in,
  output logic                     invShiftRow_ready_out,
  input  logic [DATA_WIDTH-1:0]    invShiftRow_data_in,
  output logic [DATA_WIDTH-1:0]    invShiftRow_data_out,
  output logic                     invShiftRow_valid_out,
  input  logic                     invShiftRow_ready_in,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   invShiftRow_count
);

  import inv_shift_row_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DATA_WIDTH != 128 || (DEPTH != 2 && DEPTH != 4)) begin : g_bad_param
    $error("inv_shift_row: DATA_WIDTH must be 128 and DEPTH 2 or 4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] perm_data;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          ready_reg,  ready_next;
  logic          push, pop, valid;

  inv_shift_row_perm u_perm (
    .data_in  (invShiftRow_data_in),
    .data_out (perm_data)
  );

  assign valid = (count_reg != '0);
  assign push  = invShiftRow_valid_in && ready_reg;
  assign pop   = valid && invShiftRow_ready_in;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
    // ready is registered from the next occupancy, so a pop on a full edge
    // only reopens the input one cycle later.
    ready_next = (count_next < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ready_reg  <= ready_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !flush) begin
      mem[wr_ptr_reg] <= perm_data;
    end
  end

  assign invShiftRow_ready_out = ready_reg;
  assign invShiftRow_valid_out = valid;
  assign invShiftRow_count     = count_reg;
  assign invShiftRow_data_out  = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_inv_shift_row.sv
// Directed bench for inv_shift_row: inputs driven and outputs sampled on the falling edge.
module tb_inv_shift_row;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic         flush;
  logic [1:0]   count;

  int cmp_count = 0;
  int err_count = 0;

  localparam logic [127:0] V0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E0 = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] V1 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] V2 = 128'hdeadbeef0123456789abcdeffedcba98;

  inv_shift_row #(.DATA_WIDTH(128), .DEPTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .invShiftRow_valid_in  (valid_in),
    .invShiftRow_ready_out (ready_out),
    .invShiftRow_data_in   (data_in),
    .invShiftRow_data_out  (data_out),
    .invShiftRow_valid_out (valid_out),
    .invShiftRow_ready_in  (ready_in),
    .flush                 (flush),
    .invShiftRow_count     (count)
  );

  always #5 clk = ~clk;

  // Reference by row/column rule: out[r][c] = in[r][(c-r) mod 4].
  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(((c-r)+4)%4)+r) -: 8];
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    cmp_count++;
    if (ready_out !== 1'b0 || valid_out !== 1'b0 || count !== 2'd0 || data_out !== '0) begin
      err_count++;
      $display("FAIL reset_state: ready=%b valid=%b count=%0d data=%h, want 0/0/0/0", ready_out, valid_out, count, data_out);
    end
    rst = 1'b1;
    @(negedge clk);
    cmp_count++;
    if (ready_out !== 1'b1) begin
      err_count++;
      $display("FAIL reset_release_ready: ready=%b want 1", ready_out);
    end
    $display("reset done");
  endtask

  task automatic test_vector(input logic [127:0] vin, input logic [127:0] vexp, input string name);
    ready_in = 1'b1;
    valid_in = 1'b1; data_in = vin;
    @(negedge clk);
    valid_in = 1'b0;
    cmp_count++;
    if (valid_out !== 1'b1 || data_out !== vexp || count !== 2'd1) begin
      err_count++;
      $display("FAIL %s: valid=%b count=%0d data=%h, want 1/1/%h", name, valid_out, count, data_out, vexp);
    end
    $display("vector %s in=%h out=%h", name, vin, data_out);
    @(negedge clk);
    cmp_count++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      err_count++;
      $display("FAIL %s_drain: valid=%b data=%h, want 0/0", name, valid_out, data_out);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = V0;
    @(negedge clk);
    data_in = V1;
    @(negedge clk);
    data_in = V2;
    @(negedge clk);
    valid_in = 1'b0;
    cmp_count++;
    if (count !== 2'd2 || ready_out !== 1'b0 || data_out !== E0) begin
      err_count++;
      $display("FAIL bp_full: count=%0d ready=%b data=%h, want 2/0/%h", count, ready_out, data_out, E0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    cmp_count++;
    if (count !== 2'd1 || ready_out !== 1'b1 || data_out !== V0) begin
      err_count++;
      $display("FAIL bp_first_pop: count=%0d ready=%b data=%h, want 1/1/%h", count, ready_out, data_out, V0);
    end
    $display("bp pop1 data=%h", data_out);
    @(negedge clk);
    cmp_count++;
    if (count !== 2'd0 || valid_out !== 1'b0) begin
      err_count++;
      $display("FAIL bp_second_pop: count=%0d valid=%b, want 0/0", count, valid_out);
    end
  endtask

  task automatic test_stream();
    logic [127:0] vec [11];
    logic [127:0] exp_q [11];
    for (int k = 0; k < 11; k++) begin
      for (int b = 0; b < 16; b++) vec[k][127-8*b -: 8] = 8'(16*k + b);
      exp_q[k] = ref_inv(vec[k]);
    end
    ready_in = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) begin
        cmp_count++;
        if (valid_out !== 1'b1 || count !== 2'd1 || data_out !== exp_q[i-1]) begin
          err_count++;
          $display("FAIL stream_%0d: valid=%b count=%0d data=%h, want 1/1/%h", i-1, valid_out, count, data_out, exp_q[i-1]);
        end
        $display("stream out[%0d]=%h", i-1, data_out);
      end
      if (i < 11) begin
        cmp_count++;
        if (ready_out !== 1'b1) begin
          err_count++;
          $display("FAIL stream_ready_%0d: ready=%b want 1", i, ready_out);
        end
        valid_in = 1'b1; data_in = vec[i];
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
    end
    cmp_count++;
    if (count !== 2'd0 || valid_out !== 1'b0) begin
      err_count++;
      $display("FAIL stream_drain: count=%0d valid=%b, want 0/0", count, valid_out);
    end
  endtask

  task automatic test_flush(input int fill);
    ready_in = 1'b0;
    for (int i = 0; i < fill; i++) begin
      valid_in = 1'b1; data_in = V0;
      @(negedge clk);
    end
    flush = 1'b1; valid_in = 1'b1; data_in = V2;
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0;
    cmp_count++;
    if (count !== 2'd0 || valid_out !== 1'b0 || data_out !== '0 || ready_out !== 1'b1) begin
      err_count++;
      $display("FAIL flush_fill%0d: count=%0d valid=%b ready=%b data=%h, want 0/0/1/0", fill, count, valid_out, ready_out, data_out);
    end
    @(negedge clk);
    cmp_count++;
    if (count !== 2'd0 || valid_out !== 1'b0) begin
      err_count++;
      $display("FAIL flush_nocapture_fill%0d: count=%0d valid=%b, want 0/0", fill, count, valid_out);
    end
    $display("flush with %0d buffered done", fill);
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = V1;
    @(negedge clk);
    data_in = V2;
    @(negedge clk);
    valid_in = 1'b0;
    cmp_count++;
    if (count !== 2'd2) begin
      err_count++;
      $display("FAIL rstmid_fill: count=%0d want 2", count);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp_count++;
    if (count !== 2'd0 || valid_out !== 1'b0 || data_out !== '0 || ready_out !== 1'b0) begin
      err_count++;
      $display("FAIL rstmid_clear: count=%0d valid=%b ready=%b data=%h, want 0/0/0/0", count, valid_out, ready_out, data_out);
    end
    rst = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    cmp_count++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      err_count++;
      $display("FAIL rstmid_release: ready=%b valid=%b, want 1/0", ready_out, valid_out);
    end
    test_vector(V0, E0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector(V0, E0, "req032");
    test_vector(V1, V0, "req033");
    test_vector(V2, ref_inv(V2), "mixed");
    test_backpressure();
    test_stream();
    test_flush(2);
    test_flush(1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
